// File: rtl/pwm_timebase_mc.sv
// pwm_timebase_mc: shared PWM counter (up, up-down, down, one-shot) with
// NUM_CH registered compare outputs. Period and compare values pass through
// a pending stage and reach the active set only at a counting boundary.
module pwm_timebase_mc #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 4
) (
  input  logic                    clk,
  input  logic                    cnt_rst_n,
  input  logic                    pwm_en,
  input  logic [1:0]              mode,
  input  logic [WIDTH-1:0]        period_in,
  input  logic [NUM_CH*WIDTH-1:0] cmp_in,
  input  logic                    load,
  output logic [WIDTH-1:0]        cnt_val,
  output logic                    dir,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_evt,
  output logic                    zero_evt,
  output logic                    upd_pend,
  output logic                    done
);

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_UPDN    = 2'b01,
    MODE_DOWN    = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0]        per_p;
  logic [WIDTH-1:0]        per_a;
  logic [WIDTH-1:0]        per_n;
  logic [NUM_CH*WIDTH-1:0] cmp_p;
  logic [NUM_CH*WIDTH-1:0] cmp_a;
  logic [NUM_CH*WIDTH-1:0] cmp_n;
  mode_t                   mode_a;
  logic                    upd_pt;
  logic                    xfer;
  logic [WIDTH-1:0]        cnt_n;
  logic                    dir_n;
  logic                    done_n;
  logic [NUM_CH-1:0]       pwm_n;

  // Boundary detection and the active values the counter step will use
  always_comb begin
    upd_pt = 1'b0;
    case (mode_a)
      MODE_UP:      upd_pt = (cnt_val >= per_a);
      MODE_ONESHOT: upd_pt = !done && (cnt_val >= per_a);
      MODE_DOWN:    upd_pt = (cnt_val == ZERO);
      // a zero period parks the counter at the valley, so it counts as one
      MODE_UPDN:    upd_pt = (cnt_val == ZERO) && (dir || (per_a == ZERO));
    endcase
    xfer  = pwm_en ? (upd_pt && (upd_pend || load)) : (upd_pend || load);
    per_n = per_a;
    cmp_n = cmp_a;
    if (xfer) begin
      per_n = load ? period_in : per_p;
      cmp_n = load ? cmp_in    : cmp_p;
    end
  end

  // Next counter, direction and done values for the active mode
  always_comb begin
    cnt_n  = cnt_val;
    dir_n  = dir;
    done_n = done;
    if (!pwm_en) begin
      cnt_n  = ZERO;
      dir_n  = 1'b0;
      done_n = 1'b0;
    end else begin
      case (mode_a)
        MODE_UP: begin
          dir_n = 1'b0;
          cnt_n = (cnt_val >= per_a) ? ZERO : cnt_val + ONE;
        end
        MODE_DOWN: begin
          if (cnt_val == ZERO) begin
            cnt_n = per_n;
            dir_n = (per_n != ZERO);
          end else begin
            cnt_n = cnt_val - ONE;
            dir_n = 1'b1;
          end
        end
        MODE_UPDN: begin
          if (per_n == ZERO) begin
            cnt_n = ZERO;
            dir_n = 1'b0;
          end else if (!dir) begin
            if (cnt_val >= per_n) begin
              dir_n = 1'b1;
              cnt_n = cnt_val - ONE;
            end else begin
              cnt_n = cnt_val + ONE;
            end
          end else begin
            if (cnt_val == ZERO) begin
              dir_n = 1'b0;
              cnt_n = ONE;
            end else begin
              cnt_n = cnt_val - ONE;
            end
          end
        end
        MODE_ONESHOT: begin
          dir_n = 1'b0;
          if (!done) begin
            if (cnt_val >= per_a) begin
              done_n = 1'b1;
            end else begin
              cnt_n = cnt_val + ONE;
            end
          end
        end
      endcase
    end
  end

  // Per-channel compare against the current count
  always_comb begin
    pwm_n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_n[i] = (cnt_val < cmp_a[i*WIDTH +: WIDTH]);
    end
  end

  // Pending/active register sets and the pending flag
  always_ff @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) begin
      per_p    <= '0;
      cmp_p    <= '0;
      per_a    <= '0;
      cmp_a    <= '0;
      mode_a   <= MODE_UP;
      upd_pend <= 1'b0;
    end else begin
      if (load) begin
        per_p <= period_in;
        cmp_p <= cmp_in;
      end
      per_a <= per_n;
      cmp_a <= cmp_n;
      if (!pwm_en) begin
        mode_a <= mode_t'(mode);
      end
      upd_pend <= xfer ? 1'b0 : (load | upd_pend);
    end
  end

  // Counter, direction, events and PWM outputs
  always_ff @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) begin
      cnt_val    <= '0;
      dir        <= 1'b0;
      done       <= 1'b0;
      pwm_out    <= '0;
      period_evt <= 1'b0;
      zero_evt   <= 1'b0;
    end else begin
      cnt_val    <= cnt_n;
      dir        <= dir_n;
      done       <= done_n;
      pwm_out    <= pwm_en ? pwm_n : '0;
      period_evt <= pwm_en && (cnt_val == per_a);
      zero_evt   <= pwm_en && (cnt_val == ZERO);
    end
  end

endmodule
